// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage with valid/ready handshake, two-entry skid buffer and flush.
// Optional forwarding tap enabled by defining MEM_WB_FWD_EN; otherwise fwd_* read zero.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [REG_W-1:0]  WriteReg,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [ADDR_W-1:0] address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_MemtoReg,
  output logic              out_RegWrite,
  output logic [REG_W-1:0]  out_WriteReg,
  output logic [DATA_W-1:0] out_ReadData,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        occupancy,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occState_t;

  typedef struct packed {
    logic              memtoReg;
    logic              regWrite;
    logic [REG_W-1:0]  writeReg;
    logic [DATA_W-1:0] readData;
    logic [ADDR_W-1:0] address;
  } entry_t;

  occState_t   state, stateNext;
  entry_t      head, skid, inEntry;
  logic        accept, drain;
  logic        loadHeadIn, loadHeadSkid, loadSkid;
  logic [DATA_W-1:0] addrResized;

  assign inEntry   = '{memtoReg: MemtoReg, regWrite: RegWrite, writeReg: WriteReg,
                       readData: ReadData, address: address};
  // in_ready comes from registered state only, so out_ready never reaches it combinationally.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    stateNext    = state;
    loadHeadIn   = 1'b0;
    loadHeadSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          stateNext  = ONE;
          loadHeadIn = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            loadHeadIn = 1'b1;
          end else if (accept) begin
            stateNext = FULL;
            loadSkid  = 1'b1;
          end else if (drain) begin
            stateNext = EMPTY;
          end
        end
        FULL: if (drain) begin
          stateNext    = ONE;
          loadHeadSkid = 1'b1;
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= EMPTY;
      // NOTE: payload registers are reset too, because out_* and wb_data must read zero after reset.
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= stateNext;
      if (loadHeadIn)        head <= inEntry;
      else if (loadHeadSkid) head <= skid;
      if (loadSkid)          skid <= inEntry;
    end
  end

  generate
    if (ADDR_W >= DATA_W) begin : gTrunc
      assign addrResized = head.address[DATA_W-1:0];
    end else begin : gZext
      assign addrResized = {{(DATA_W-ADDR_W){1'b0}}, head.address};
    end
  endgenerate

  // Stale payload survives a flush; gating RegWrite keeps writeback from firing on it.
  assign out_MemtoReg = head.memtoReg;
  assign out_RegWrite = head.regWrite & out_valid;
  assign out_WriteReg = head.writeReg;
  assign out_ReadData = head.readData;
  assign out_address  = head.address;
  assign wb_data      = head.memtoReg ? head.readData : addrResized;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = out_valid & out_RegWrite & (out_WriteReg != '0);
  assign fwd_reg   = out_WriteReg;
  assign fwd_data  = wb_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_reg   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Table-driven bench for mem_wb_stage (DATA_W=32, ADDR_W=16); each row is one clock edge.
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 5;

  logic              clock = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic              MemtoReg, RegWrite, out_MemtoReg, out_RegWrite, fwd_valid;
  logic [REG_W-1:0]  WriteReg, out_WriteReg, fwd_reg;
  logic [DATA_W-1:0] ReadData, out_ReadData, wb_data, fwd_data;
  logic [ADDR_W-1:0] address, out_address;
  logic [1:0]        occupancy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clock(clock), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .ReadData(ReadData), .address(address),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_MemtoReg(out_MemtoReg), .out_RegWrite(out_RegWrite),
    .out_WriteReg(out_WriteReg), .out_ReadData(out_ReadData),
    .out_address(out_address), .wb_data(wb_data), .occupancy(occupancy),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  typedef struct {
    logic        rst, flush, inValid, outReady, m2r, rw;
    logic [4:0]  wr;
    logic [31:0] rd;
    logic [15:0] ad;
    logic        eOv, eIr;
    logic [1:0]  eOcc;
    logic        eM2r, eRw;
    logic [4:0]  eWr;
    logic [31:0] eRd;
    logic [15:0] eAd;
    logic [31:0] eWb;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic f, input logic iv, input logic ordy,
    input logic m, input logic w, input logic [4:0] wr, input logic [31:0] rd,
    input logic [15:0] ad,
    input logic eOv, input logic eIr, input logic [1:0] eOcc, input logic eM,
    input logic eW, input logic [4:0] eWr, input logic [31:0] eRd,
    input logic [15:0] eAd, input logic [31:0] eWb);
    vec_t v;
    v.rst = r; v.flush = f; v.inValid = iv; v.outReady = ordy;
    v.m2r = m; v.rw = w; v.wr = wr; v.rd = rd; v.ad = ad;
    v.eOv = eOv; v.eIr = eIr; v.eOcc = eOcc; v.eM2r = eM; v.eRw = eW;
    v.eWr = eWr; v.eRd = eRd; v.eAd = eAd; v.eWb = eWb;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  vec_t vecs[25];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    MemtoReg = 1'b0; RegWrite = 1'b0; WriteReg = '0; ReadData = '0; address = '0;

    //          rst f iv or m w wr  ReadData       addr      ov ir occ m w wr  eRd            eAd       eWb
    // reset held two cycles with live input
    vecs[0]  = mk(1, 0, 1, 1, 1, 1, 9,  32'hDEAD_BEEF, 16'h1234, 0, 1, 0, 0, 0, 0,  32'h0,         16'h0,    32'h0);
    vecs[1]  = mk(1, 0, 1, 1, 1, 1, 9,  32'hDEAD_BEEF, 16'h1234, 0, 1, 0, 0, 0, 0,  32'h0,         16'h0,    32'h0);
    // streaming, one per cycle
    vecs[2]  = mk(0, 0, 1, 1, 1, 1, 1,  32'h11,        16'h0101, 1, 1, 1, 1, 1, 1,  32'h11,        16'h0101, 32'h11);
    vecs[3]  = mk(0, 0, 1, 1, 1, 1, 2,  32'h22,        16'h0202, 1, 1, 1, 1, 1, 2,  32'h22,        16'h0202, 32'h22);
    vecs[4]  = mk(0, 0, 1, 1, 1, 1, 3,  32'h33,        16'h0303, 1, 1, 1, 1, 1, 3,  32'h33,        16'h0303, 32'h33);
    vecs[5]  = mk(0, 0, 1, 1, 1, 1, 4,  32'h44,        16'h0404, 1, 1, 1, 1, 1, 4,  32'h44,        16'h0404, 32'h44);
    vecs[6]  = mk(0, 0, 0, 1, 0, 0, 0,  32'h0,         16'h0,    0, 1, 0, 1, 0, 4,  32'h44,        16'h0404, 32'h44);
    // stall: A then B fill the buffer, C held off, then drain A, B, C
    vecs[7]  = mk(0, 0, 1, 0, 0, 1, 5,  32'hAAAA_0000, 16'h00A5, 1, 1, 1, 0, 1, 5,  32'hAAAA_0000, 16'h00A5, 32'h0000_00A5);
    vecs[8]  = mk(0, 0, 1, 0, 1, 0, 6,  32'hBBBB_0001, 16'h00B6, 1, 0, 2, 0, 1, 5,  32'hAAAA_0000, 16'h00A5, 32'h0000_00A5);
    vecs[9]  = mk(0, 0, 1, 0, 1, 1, 7,  32'hCCCC_0002, 16'h00C7, 1, 0, 2, 0, 1, 5,  32'hAAAA_0000, 16'h00A5, 32'h0000_00A5);
    vecs[10] = mk(0, 0, 1, 1, 1, 1, 7,  32'hCCCC_0002, 16'h00C7, 1, 1, 1, 1, 0, 6,  32'hBBBB_0001, 16'h00B6, 32'hBBBB_0001);
    vecs[11] = mk(0, 0, 1, 1, 1, 1, 7,  32'hCCCC_0002, 16'h00C7, 1, 1, 1, 1, 1, 7,  32'hCCCC_0002, 16'h00C7, 32'hCCCC_0002);
    vecs[12] = mk(0, 0, 0, 1, 0, 0, 0,  32'h0,         16'h0,    0, 1, 0, 1, 0, 7,  32'hCCCC_0002, 16'h00C7, 32'hCCCC_0002);
    // flush while FULL with concurrent input
    vecs[13] = mk(0, 0, 1, 0, 0, 1, 8,  32'hDDDD_0003, 16'hD0D8, 1, 1, 1, 0, 1, 8,  32'hDDDD_0003, 16'hD0D8, 32'h0000_D0D8);
    vecs[14] = mk(0, 0, 1, 0, 1, 1, 9,  32'hEEEE_0004, 16'hE0E9, 1, 0, 2, 0, 1, 8,  32'hDDDD_0003, 16'hD0D8, 32'h0000_D0D8);
    vecs[15] = mk(0, 1, 1, 0, 1, 1, 10, 32'hFFFF_0005, 16'hF0FA, 0, 1, 0, 0, 0, 8,  32'hDDDD_0003, 16'hD0D8, 32'h0000_D0D8);
    // flush in ONE beats a same-cycle accept and drain
    vecs[16] = mk(0, 0, 1, 1, 0, 1, 11, 32'h0,         16'h0011, 1, 1, 1, 0, 1, 11, 32'h0,         16'h0011, 32'h11);
    vecs[17] = mk(0, 1, 1, 1, 1, 1, 12, 32'h1212_1212, 16'h0012, 0, 1, 0, 0, 0, 11, 32'h0,         16'h0011, 32'h11);
    vecs[18] = mk(0, 0, 0, 1, 0, 0, 0,  32'h0,         16'h0,    0, 1, 0, 0, 0, 11, 32'h0,         16'h0011, 32'h11);
    // mux / zero-extension and forwarding tap
    vecs[19] = mk(0, 0, 1, 0, 0, 1, 7,  32'h1234_5678, 16'hBEEF, 1, 1, 1, 0, 1, 7,  32'h1234_5678, 16'hBEEF, 32'h0000_BEEF);
    vecs[20] = mk(0, 0, 1, 1, 0, 1, 7,  32'h0,         16'h0005, 1, 1, 1, 0, 1, 7,  32'h0,         16'h0005, 32'h5);
    vecs[21] = mk(0, 0, 1, 1, 0, 1, 0,  32'h0,         16'h0006, 1, 1, 1, 0, 1, 0,  32'h0,         16'h0006, 32'h6);
    // rst mid-stall drops both entries
    vecs[22] = mk(0, 0, 1, 0, 1, 1, 3,  32'h31,        16'h0031, 1, 0, 2, 0, 1, 0,  32'h0,         16'h0006, 32'h6);
    vecs[23] = mk(1, 0, 1, 0, 1, 1, 3,  32'h31,        16'h0031, 0, 1, 0, 0, 0, 0,  32'h0,         16'h0,    32'h0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, 0,  32'h0,         16'h0,    0, 1, 0, 0, 0, 0,  32'h0,         16'h0,    32'h0);

    for (int i = 0; i < 25; i++) begin
      logic        eFv;
      logic [4:0]  eFr;
      logic [31:0] eFd;
      rst = vecs[i].rst; flush = vecs[i].flush;
      in_valid = vecs[i].inValid; out_ready = vecs[i].outReady;
      MemtoReg = vecs[i].m2r; RegWrite = vecs[i].rw; WriteReg = vecs[i].wr;
      ReadData = vecs[i].rd; address = vecs[i].ad;
      @(posedge clock);
      #1;
`ifdef MEM_WB_FWD_EN
      eFv = vecs[i].eOv & vecs[i].eRw & (vecs[i].eWr != 5'd0);
      eFr = vecs[i].eWr;
      eFd = vecs[i].eWb;
`else
      eFv = 1'b0;
      eFr = 5'd0;
      eFd = 32'h0;
`endif
      check("out_valid",    i, {31'b0, out_valid},    {31'b0, vecs[i].eOv});
      check("in_ready",     i, {31'b0, in_ready},     {31'b0, vecs[i].eIr});
      check("occupancy",    i, {30'b0, occupancy},    {30'b0, vecs[i].eOcc});
      check("out_MemtoReg", i, {31'b0, out_MemtoReg}, {31'b0, vecs[i].eM2r});
      check("out_RegWrite", i, {31'b0, out_RegWrite}, {31'b0, vecs[i].eRw});
      check("out_WriteReg", i, {27'b0, out_WriteReg}, {27'b0, vecs[i].eWr});
      check("out_ReadData", i, out_ReadData,          vecs[i].eRd);
      check("out_address",  i, {16'b0, out_address},  {16'b0, vecs[i].eAd});
      check("wb_data",      i, wb_data,               vecs[i].eWb);
      check("fwd_valid",    i, {31'b0, fwd_valid},    {31'b0, eFv});
      check("fwd_reg",      i, {27'b0, fwd_reg},      {27'b0, eFr});
      check("fwd_data",     i, fwd_data,              eFd);
    end

    // Hand sequence: full-rate streaming of 6 entries, each visible exactly one cycle after accept.
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      WriteReg = 5'(k + 1);
      ReadData = 32'h5000 + 32'(k);
      address  = 16'(k);
      @(posedge clock);
      #1;
      check("stream_valid", 100 + k, {31'b0, out_valid}, 32'h1);
      check("stream_data",  100 + k, wb_data, 32'h5000 + 32'(k));
    end
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    check("stream_empty", 106, {30'b0, occupancy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer. It sits between data memory and register-file writeback. It carries the writeback control (MemtoReg, RegWrite, WriteReg), the memory read data and the ALU address/result. The writeback-data select is resolved inside the stage. Unlike the plain MEM/WB register it supports downstream stall without losing data, flush of in-flight entries, and an optional forwarding tap.

## Interface
Parameters:
- DATA_W, 32, width of ReadData and wb_data
- ADDR_W, 32, width of address (ALU result)
- REG_W, 5, register index width

Ports:
- clock  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all held entries at next edge
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- MemtoReg  in  1  select ReadData for writeback
- RegWrite  in  1  writeback enable
- WriteReg  in  REG_W  destination register
- ReadData  in  DATA_W  memory read data
- address  in  ADDR_W  ALU result / address
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes head
- out_MemtoReg, out_RegWrite  out  1 each  head control fields
- out_WriteReg  out  REG_W  head destination
- out_ReadData  out  DATA_W  head read data
- out_address  out  ADDR_W  head address
- wb_data  out  DATA_W  resolved writeback value of head
- occupancy  out  2  held entries, 0..2
- fwd_valid  out  1  forwarding tap valid (see Configuration)
- fwd_reg  out  REG_W  forwarding tap register index
- fwd_data  out  DATA_W  forwarding tap data

## Operation
- Storage: head slot (drives out_*) and skid slot; occupancy states EMPTY=0, ONE=1, FULL=2.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !skid_valid (registered state, no combinational path from out_ready).
- Transitions:
  - EMPTY + accept -> ONE, head loads input.
  - ONE + accept & drain -> ONE, head reloads input.
  - ONE + accept & !drain -> FULL, skid loads input.
  - ONE + !accept & drain -> EMPTY.
  - FULL + drain -> ONE, skid moves to head.
  - FULL + !drain -> FULL, hold. in_ready=0 in FULL.
- Order strictly FIFO; no entry dropped or duplicated except by flush/rst.
- out_RegWrite = stored RegWrite & out_valid. Writeback never fires from an invalid head.
- wb_data = out_MemtoReg ? out_ReadData : address resized to DATA_W. Resize zero-extends if ADDR_W<DATA_W and truncates to the low DATA_W bits if larger. Combinational from head.
- flush: next edge clears both valid bits, occupancy=0. A same-cycle accept is discarded; flush beats accept and drain. Payload registers keep stale values, but out_RegWrite=0.
- rst priority: rst > flush > handshake.

## Timing
- Reset values (cycle after rst sampled high):
  - out_valid=0, occupancy=0, in_ready=1.
  - All out_* payload = 0, wb_data=0, fwd_*=0.
  - Inputs are ignored while rst=1.
- Latency: from EMPTY, input accepted at edge N is on out_* after edge N, i.e. in cycle N+1.
- Throughput: 1 entry/cycle when out_ready held high.
- in_ready falls the cycle after the entry that fills skid. It rises the cycle after a drain in FULL.
- occupancy is registered and updates on the same edge as the valid bits.
- rst or flush asserted mid-stall drops both entries. in_ready=1 in the following cycle.

## Configuration
- MEM_WB_FWD_EN defined:
  - fwd_valid = out_valid & out_RegWrite & (out_WriteReg != 0).
  - fwd_reg = out_WriteReg.
  - fwd_data = wb_data.
  - All three are combinational from the head.
- MEM_WB_FWD_EN undefined: fwd_valid, fwd_reg and fwd_data are tied to constant 0. The ports still exist.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, occupancy=0, in_ready=1, all payload 0.
- Streaming: 4 entries (ReadData=0x11..0x44, MemtoReg=1), out_ready=1 -> one per cycle, in order, each 1 cycle after accept; wb_data=0x11..0x44.
- Stall/skid: out_ready=0, push A then B -> occupancy 2, in_ready=0, C held off. Raise out_ready -> A, B, C drained in order with no loss.
- Flush while FULL with concurrent in_valid=1 -> next cycle out_valid=0, occupancy=0, out_RegWrite=0; concurrent input not stored.
- Mux/width: DATA_W=32, ADDR_W=16, MemtoReg=0, address=0xBEEF -> wb_data=0x0000BEEF.
- Forwarding with MEM_WB_FWD_EN: RegWrite=1, WriteReg=7, address=0x5 -> fwd_valid=1, fwd_reg=7, fwd_data=5. With WriteReg=0 -> fwd_valid=0. Without macro -> fwd_* stay 0.
